// File: rtl/touch_key_tx_pkg.sv
// Shared definitions for the touch-key emulator: FSM state encoding,
// default timing constants and a hold-length normalisation helper.
package touch_key_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_B_ON  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_B_OFF = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int unsigned DEF_BOUNCE_N   = 3;
    localparam int unsigned DEF_BOUNCE_CYC = 16;
    localparam int unsigned DEF_GAP_CYC    = 1000;

    // A zero hold length still produces one stable-high clock.
    function automatic logic [15:0] eff_hold(input logic [15:0] len);
        return (len == '0) ? 16'd1 : len;
    endfunction

endpackage

// File: rtl/touch_key_tx_bounce_gen.sv
// tkt_bounce_gen: square-wave burst generator used for contact bounce.
// After a start pulse it produces BOUNCE_N periods, each BOUNCE_CYC clocks
// at 'polarity' followed by BOUNCE_CYC clocks at ~polarity.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   start            : load and begin a burst (takes effect at this edge)
//   polarity         : level of the first half-period
//   wave_next        : level the wave will have in the next cycle
//   done             : high in the last clock of the burst
module tkt_bounce_gen #(
    parameter int unsigned BOUNCE_N   = 3,
    parameter int unsigned BOUNCE_CYC = 16
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    input  logic polarity,
    output logic wave_next,
    output logic done
);

    localparam int unsigned RW = (BOUNCE_N < 2) ? 1 : $clog2(BOUNCE_N + 1);

    logic [15:0]   cnt, cnt_n;
    logic [RW-1:0] rep, rep_n;
    logic          half, half_n;
    logic          act, act_n;
    logic          pol_q, pol_n;

    always_comb begin
        cnt_n  = cnt;
        rep_n  = rep;
        half_n = half;
        act_n  = act;
        pol_n  = pol_q;
        if (start) begin
            act_n  = 1'b1;
            cnt_n  = 16'(BOUNCE_CYC);
            half_n = 1'b0;
            rep_n  = RW'(BOUNCE_N);
            pol_n  = polarity;
        end else if (act) begin
            if (cnt == 16'd1) begin
                if (!half) begin
                    half_n = 1'b1;
                    cnt_n  = 16'(BOUNCE_CYC);
                end else if (rep == RW'(1)) begin
                    act_n  = 1'b0;
                    half_n = 1'b0;
                end else begin
                    rep_n  = rep - RW'(1);
                    half_n = 1'b0;
                    cnt_n  = 16'(BOUNCE_CYC);
                end
            end else begin
                cnt_n = cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt   <= '0;
            rep   <= '0;
            half  <= 1'b0;
            act   <= 1'b0;
            pol_q <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            rep   <= rep_n;
            half  <= half_n;
            act   <= act_n;
            pol_q <= pol_n;
        end
    end

    // Exposed one cycle early so the parent can register touch_key.
    assign wave_next = pol_n ^ half_n;
    assign done      = act && (cnt == 16'd1) && half && (rep == RW'(1));

endmodule

// File: rtl/touch_key_tx.sv
// touch_key_tx: emulates a mechanical/touch key press sequence.
// Per accepted request: press bounce, stable hold, release bounce, low gap.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   req              : press request (level)
//   hold_len         : stable-high clocks, latched on acceptance (0 -> 1)
//   ack              : one-cycle acceptance pulse
//   busy             : high while a press sequence runs
//   done             : one-cycle pulse after the gap
//   touch_key        : registered emulated key waveform
//   press_cnt        : completed-press counter, wraps at 256
module touch_key_tx
    import touch_key_tx_pkg::*;
#(
    parameter int unsigned BOUNCE_N   = DEF_BOUNCE_N,
    parameter int unsigned BOUNCE_CYC = DEF_BOUNCE_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req,
    input  logic [15:0] hold_len,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic        touch_key,
    output logic [7:0]  press_cnt
);

    state_t      state, state_n;
    logic [15:0] dur_cnt, dur_n;
    logic [15:0] hold_q, hold_n;
    logic        accept;
    logic        b_start, b_pol, b_wave_next, b_done;
    logic        tk_n, ack_n, busy_n, done_n;

    tkt_bounce_gen #(
        .BOUNCE_N   (BOUNCE_N),
        .BOUNCE_CYC (BOUNCE_CYC)
    ) u_bounce (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (b_start),
        .polarity  (b_pol),
        .wave_next (b_wave_next),
        .done      (b_done)
    );

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE:  if (req) state_n = (BOUNCE_N > 0) ? ST_B_ON : ST_HOLD;
            ST_B_ON:  if (b_done) state_n = ST_HOLD;
            ST_HOLD:  if (dur_cnt == 16'd1) state_n = (BOUNCE_N > 0) ? ST_B_OFF : ST_GAP;
            ST_B_OFF: if (b_done) state_n = ST_GAP;
            ST_GAP:   if (dur_cnt == 16'd1) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Output / datapath next values; everything visible is registered below,
    // so each value here is what the next cycle will show.
    always_comb begin
        accept  = (state == ST_IDLE) && req;
        b_start = ((state_n == ST_B_ON)  && (state != ST_B_ON)) ||
                  ((state_n == ST_B_OFF) && (state != ST_B_OFF));
        b_pol   = (state_n == ST_B_ON);
        hold_n  = accept ? eff_hold(hold_len) : hold_q;

        dur_n = dur_cnt;
        if ((state_n == ST_HOLD) && (state != ST_HOLD))
            dur_n = (state == ST_IDLE) ? eff_hold(hold_len) : hold_q;
        else if ((state_n == ST_GAP) && (state != ST_GAP))
            dur_n = 16'(GAP_CYC);
        else if ((state == ST_HOLD) || (state == ST_GAP))
            dur_n = dur_cnt - 16'd1;

        unique case (state_n)
            ST_HOLD:           tk_n = 1'b1;
            ST_B_ON, ST_B_OFF: tk_n = b_wave_next;
            default:           tk_n = 1'b0;
        endcase

        ack_n  = accept;
        busy_n = (state_n != ST_IDLE);
        done_n = (state == ST_GAP) && (state_n == ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            touch_key <= 1'b0;
            press_cnt <= '0;
            dur_cnt   <= '0;
            hold_q    <= '0;
        end else begin
            ack       <= ack_n;
            busy      <= busy_n;
            done      <= done_n;
            touch_key <= tk_n;
            dur_cnt   <= dur_n;
            hold_q    <= hold_n;
            if (done_n) press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule
